// File: rtl/ongoru_zamanlayici.sv
// ongoru_zamanlayici: replays a branch trace into a predictor under test.
// Each trace entry is read, issued as a prediction request, and answered by
// the predictor. The outcome is delayed RESOLVE_LAT cycles to emulate the EX
// stage. The delayed outcome drives the predictor update port and the
// branch/misprediction counters.
module ongoru_zamanlayici #(
  parameter int BRANCH_COUNT = 1024,
  parameter int SIM_LEN      = 1000,
  parameter int RESOLVE_LAT  = 2,
  parameter int PC_LEN       = 32,
  parameter int INST_LEN     = 32,
  localparam int PTR_W       = (BRANCH_COUNT > 1) ? $clog2(BRANCH_COUNT) : 1,
  localparam int ENTRY_LEN   = 2*PC_LEN + INST_LEN + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 trace_rd_o,
  output logic [PTR_W-1:0]     trace_addr_o,
  input  logic [ENTRY_LEN-1:0] trace_data_i,
  output logic                 pred_req_valid_o,
  input  logic                 pred_req_ready_i,
  output logic [PC_LEN-1:0]    pred_pc_o,
  output logic [INST_LEN-1:0]  pred_inst_o,
  input  logic                 pred_resp_valid_i,
  input  logic                 pred_taken_i,
  input  logic [PC_LEN-1:0]    pred_target_i,
  output logic                 upd_valid_o,
  output logic [PC_LEN-1:0]    upd_pc_o,
  output logic                 upd_taken_o,
  output logic [PC_LEN-1:0]    upd_target_o,
  output logic                 upd_mispred_o,
  output logic                 busy_o,
  output logic                 end_o,
  output logic [31:0]          br_count_o,
  output logic [31:0]          mispred_count_o
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [PC_LEN-1:0] pc;
    logic              taken;
    logic [PC_LEN-1:0] target;
    logic              mispred;
  } res_t;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [31:0]             issued_q, issued_d;
  logic                    fresh_q;
  logic [ENTRY_LEN-1:0]    entry_q;
  logic [RESOLVE_LAT-1:0]  vld_pipe_q;
  res_t [RESOLVE_LAT-1:0]  res_pipe_q;
  logic [31:0]             br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  logic [ENTRY_LEN-1:0]    cur;
  logic [PC_LEN-1:0]       cur_pc, cur_tgt;
  logic                    cur_taken;
  logic                    start_ok, hs, resp, mispred;

  // The memory answers one cycle after the read strobe. The first REQ cycle
  // therefore forwards trace_data_i directly, and later cycles use the latched copy.
  assign cur       = fresh_q ? trace_data_i : entry_q;
  assign cur_pc    = cur[PC_LEN-1:0];
  assign cur_taken = cur[PC_LEN+INST_LEN];
  assign cur_tgt   = cur[ENTRY_LEN-1 -: PC_LEN];

  assign start_ok = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign hs       = (state_q == S_REQ) & pred_req_ready_i;
  // Only WAIT listens to the predictor. The handshake cycle itself is still
  // in REQ, so it is excluded.
  assign resp     = (state_q == S_WAIT) & pred_resp_valid_i;
  assign mispred  = (pred_taken_i != cur_taken) | (cur_taken & (pred_target_i != cur_tgt));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = (SIM_LEN == 0) ? S_DONE : S_READ;
      S_READ:         state_d = S_REQ;
      S_REQ:          if (hs) state_d = S_WAIT;
      S_WAIT:         if (resp) state_d = (issued_q < 32'(SIM_LEN)) ? S_READ : S_DRAIN;
      S_DRAIN:        if (vld_pipe_q == '0) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    trace_rd_o       = (state_q == S_READ);
    pred_req_valid_o = (state_q == S_REQ);
    busy_o           = (state_q == S_READ) | (state_q == S_REQ) |
                       (state_q == S_WAIT) | (state_q == S_DRAIN);
    end_o            = (state_q == S_DONE);
  end

  assign trace_addr_o    = ptr_q;
  assign pred_pc_o       = cur_pc;
  assign pred_inst_o     = cur[PC_LEN +: INST_LEN];
  assign upd_valid_o     = vld_pipe_q[RESOLVE_LAT-1];
  assign upd_pc_o        = res_pipe_q[RESOLVE_LAT-1].pc;
  assign upd_taken_o     = res_pipe_q[RESOLVE_LAT-1].taken;
  assign upd_target_o    = res_pipe_q[RESOLVE_LAT-1].target;
  assign upd_mispred_o   = res_pipe_q[RESOLVE_LAT-1].mispred;
  assign br_count_o      = br_cnt_q;
  assign mispred_count_o = mis_cnt_q;

  // Next values for the trace pointer, issue count and saturating statistics
  always_comb begin
    ptr_d     = ptr_q;
    issued_d  = issued_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (start_ok) begin
      ptr_d     = '0;
      issued_d  = '0;
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else begin
      if (hs) begin
        issued_d = issued_q + 32'd1;
        ptr_d    = (ptr_q == PTR_W'(BRANCH_COUNT-1)) ? '0 : ptr_q + PTR_W'(1);
      end
      if (upd_valid_o && br_cnt_q != '1) br_cnt_d = br_cnt_q + 32'd1;
      if (upd_valid_o && upd_mispred_o && mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  // Pointer, counters and trace entry latch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      issued_q  <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      fresh_q   <= 1'b0;
      entry_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      issued_q  <= issued_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      fresh_q   <= (state_q == S_READ);
      if (fresh_q) entry_q <= trace_data_i;
    end
  end

  // Resolve pipeline. It shifts every cycle independent of the FSM, so the
  // next branch can be read and issued while older outcomes are in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      res_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= resp;
      res_pipe_q[0] <= '{pc: cur_pc, taken: cur_taken, target: cur_tgt, mispred: mispred};
      for (int i = 1; i < RESOLVE_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        res_pipe_q[i] <= res_pipe_q[i-1];
      end
    end
  end

endmodule
